// File: rtl/vx_tex_bilerp_sched_pkg.sv
// Shared types and constants for the bilinear texture filter scheduler.
package vx_tex_bilerp_sched_pkg;

    localparam int unsigned LERP_LATENCY = 3;
    localparam int unsigned NUM_TEXELS   = 4;
    localparam int unsigned NUM_CHANNELS = 4;
    localparam int unsigned CHANNEL_W    = 8;
    localparam int unsigned CNT_W        = 3;

    typedef logic [NUM_CHANNELS-1:0][CHANNEL_W-1:0] rgba8_t;
    typedef logic [NUM_TEXELS-1:0][NUM_CHANNELS-1:0][CHANNEL_W-1:0] texels_t;

    typedef enum logic [2:0] {
        IDLE,
        H0,
        H1,
        WAIT_H,
        V,
        WAIT_V,
        DONE
    } state_t;

endpackage

// File: rtl/vx_tex_bilerp_sched_if.sv
// Request/response handshake bundle between texel fetch and the bilinear scheduler.
interface vx_tex_bilerp_sched_if #(
    parameter int unsigned TAG_WIDTH = 8
);
    import vx_tex_bilerp_sched_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_filter;
    texels_t              req_texels;
    logic [CHANNEL_W-1:0] req_frac_u;
    logic [CHANNEL_W-1:0] req_frac_v;
    logic [TAG_WIDTH-1:0] req_tag;
    logic                 rsp_valid;
    rgba8_t               rsp_color;
    logic [TAG_WIDTH-1:0] rsp_tag;
    logic                 rsp_ready;

    modport master (
        output req_valid, req_filter, req_texels, req_frac_u, req_frac_v, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_color, rsp_tag
    );

    modport slave (
        input  req_valid, req_filter, req_texels, req_frac_u, req_frac_v, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_color, rsp_tag
    );

endinterface

// File: rtl/vx_tex_bilerp_sched_lerp_bank.sv
// Four free-running per-channel 8-bit lerps; result appears exactly three cycles after operands.
module vx_tex_bilerp_sched_lerp_bank
    import vx_tex_bilerp_sched_pkg::*;
(
    input  logic                 clk,
    input  rgba8_t               a,
    input  rgba8_t               b,
    input  logic [CHANNEL_W-1:0] frac,
    output rgba8_t               y
);

    localparam int unsigned PROD_W = 2 * CHANNEL_W;

    logic [CHANNEL_W-1:0] frac_inv;

    assign frac_inv = CHANNEL_W'(8'd255 - frac);

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [PROD_W-1:0]    p0;
        logic [PROD_W-1:0]    p1;
        logic [PROD_W-1:0]    s;
        logic [CHANNEL_W-1:0] q;

        // multiply, rounded sum, then divide by 255 via (s + s/256) / 256
        always_ff @(posedge clk) begin
            p0 <= PROD_W'(a[c]) * PROD_W'(frac_inv);
            p1 <= PROD_W'(b[c]) * PROD_W'(frac);
            s  <= p0 + p1 + PROD_W'(128);
            q  <= CHANNEL_W'((s + (s >> CHANNEL_W)) >> CHANNEL_W);
        end

        assign y[c] = q;
    end

endmodule

// File: rtl/vx_tex_bilerp_sched.sv
// Bilinear filter scheduler: two horizontal lerps then one vertical lerp on a shared lerp bank.
module vx_tex_bilerp_sched
    import vx_tex_bilerp_sched_pkg::*;
#(
    parameter int unsigned TAG_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    vx_tex_bilerp_sched_if.slave  bus
);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic                 req_ready_q;
    logic                 rsp_valid_q;
    rgba8_t               rsp_color_q;
    logic [TAG_WIDTH-1:0] rsp_tag_q;

    rgba8_t               op_a;
    rgba8_t               op_b;
    logic [CHANNEL_W-1:0] op_f;
    rgba8_t               t2_q;
    rgba8_t               t3_q;
    logic [CHANNEL_W-1:0] fv_q;
    rgba8_t               r0_q;
    rgba8_t               bank_y;

    logic handshake;
    logic cap_r0;
    logic cap_r1;
    logic cap_out;

    assign handshake = (state == IDLE) && bus.req_valid;
    assign cap_r0    = (state == WAIT_H) && (cnt == CNT_W'(LERP_LATENCY - 2));
    assign cap_r1    = (state == WAIT_H) && (cnt == CNT_W'(LERP_LATENCY - 1));
    assign cap_out   = (state == WAIT_V) && (cnt == CNT_W'(LERP_LATENCY - 1));

    // state register; cnt restarts on every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= (state_next != state) ? '0 : cnt + CNT_W'(1);
            req_ready_q <= (state_next == IDLE);
            rsp_valid_q <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.req_valid) state_next = bus.req_filter ? H0 : DONE;
            H0:      state_next = H1;
            H1:      state_next = WAIT_H;
            WAIT_H:  if (cap_r1) state_next = V;
            V:       state_next = WAIT_V;
            WAIT_V:  if (cap_out) state_next = DONE;
            DONE:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // operand registers hold their value outside H0/H1/V to keep the bank quiet
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a        <= '0;
            op_b        <= '0;
            op_f        <= '0;
            t2_q        <= '0;
            t3_q        <= '0;
            fv_q        <= '0;
            r0_q        <= '0;
            rsp_color_q <= '0;
            rsp_tag_q   <= '0;
        end else begin
            if (handshake) begin
                rsp_tag_q <= bus.req_tag;
                t2_q      <= bus.req_texels[2];
                t3_q      <= bus.req_texels[3];
                fv_q      <= bus.req_frac_v;
                if (bus.req_filter) begin
                    op_a <= bus.req_texels[0];
                    op_b <= bus.req_texels[1];
                    op_f <= bus.req_frac_u;
                end else begin
                    rsp_color_q <= bus.req_texels[0];
                end
            end
            if (state == H0) begin
                op_a <= t2_q;
                op_b <= t3_q;
            end
            if (cap_r0) r0_q <= bank_y;
            if (cap_r1) begin
                op_a <= r0_q;
                op_b <= bank_y;
                op_f <= fv_q;
            end
            if (cap_out) rsp_color_q <= bank_y;
        end
    end

    vx_tex_bilerp_sched_lerp_bank u_bank (
        .clk  (clk),
        .a    (op_a),
        .b    (op_b),
        .frac (op_f),
        .y    (bank_y)
    );

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_color = rsp_color_q;
    assign bus.rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_vx_tex_bilerp_sched.sv
// Directed bench for vx_tex_bilerp_sched with a queue of expected responses.
module tb_vx_tex_bilerp_sched;
    import vx_tex_bilerp_sched_pkg::*;

    localparam int unsigned TW = 8;

    typedef struct packed {
        logic [31:0]   color;
        logic [TW-1:0] tag;
    } exp_t;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    logic [127:0] bb_tx[3];
    logic [7:0]   bb_fu[3];
    logic [7:0]   bb_fv[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vx_tex_bilerp_sched_if #(.TAG_WIDTH(TW)) bus ();

    vx_tex_bilerp_sched #(.TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [7:0] lerp_ref(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        int unsigned s;
        s = 32'(a) * (32'd255 - 32'(f)) + 32'(b) * 32'(f) + 32'd128;
        return 8'((s + (s >> 8)) >> 8);
    endfunction

    function automatic logic [31:0] bilerp_ref(input logic [127:0] tx, input logic [7:0] fu, input logic [7:0] fv);
        logic [31:0] r;
        logic [7:0]  h0;
        logic [7:0]  h1;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            h0 = lerp_ref(tx[8*c +: 8], tx[32+8*c +: 8], fu);
            h1 = lerp_ref(tx[64+8*c +: 8], tx[96+8*c +: 8], fu);
            r[8*c +: 8] = lerp_ref(h0, h1, fv);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic filt, input logic [127:0] tx, input logic [7:0] fu,
                         input logic [7:0] fv, input logic [TW-1:0] tag);
        bus.req_valid  = 1'b1;
        bus.req_filter = filt;
        bus.req_texels = tx;
        bus.req_frac_u = fu;
        bus.req_frac_v = fv;
        bus.req_tag    = tag;
    endtask

    // returns at the falling edge of the cycle after the handshake
    task automatic send(input logic filt, input logic [127:0] tx, input logic [7:0] fu,
                        input logic [7:0] fv, input logic [TW-1:0] tag,
                        input logic [31:0] exp_color, input bit track);
        int n = 0;
        drive(filt, tx, fu, fv, tag);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_send", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        if (track) sb.push_back('{color: exp_color, tag: tag});
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic collect(input string name, input int exp_lat);
        int   n = 1;
        exp_t e;
        while (!bus.rsp_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(exp_lat));
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", name);
        end else begin
            e = sb.pop_front();
            chk({name, "_color"}, bus.rsp_color, e.color);
            chk({name, "_tag"}, 32'(bus.rsp_tag), 32'(e.tag));
        end
        if (bus.rsp_ready) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] tx;
        logic [7:0]   fu;
        logic [7:0]   fv;
        logic [31:0]  ex;
        exp_t         e;
        int           got;
        int           sent;
        int           last;
        bit           pend;

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_filter = 1'b0;
        bus.req_texels = '0;
        bus.req_frac_u = '0;
        bus.req_frac_v = '0;
        bus.req_tag    = '0;
        bus.rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_rsp_color", bus.rsp_color, 32'd0);
        chk("reset_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        @(negedge clk);

        // midpoint
        tx = {32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
        send(1'b1, tx, 8'h80, 8'h37, 8'h01, 32'h80808080, 1'b1);
        collect("midpoint", 10);

        // frac endpoints
        tx = {32'hDDEEFF00, 32'h99AABBCC, 32'h55667788, 32'h11223344};
        send(1'b1, tx, 8'hFF, 8'h00, 8'h02, 32'h55667788, 1'b1);
        collect("endpoint_u1_v0", 10);
        send(1'b1, tx, 8'h00, 8'hFF, 8'h03, 32'h99AABBCC, 1'b1);
        collect("endpoint_u0_v1", 10);

        // point sampling
        tx = {32'h01010101, 32'h02020202, 32'h03030303, 32'hCAFEBABE};
        send(1'b0, tx, 8'h40, 8'h40, 8'h5A, 32'hCAFEBABE, 1'b1);
        collect("point", 1);

        // random bilinear
        for (int i = 0; i < 4; i++) begin
            tx = {$urandom, $urandom, $urandom, $urandom};
            fu = 8'($urandom);
            fv = 8'($urandom);
            send(1'b1, tx, fu, fv, 8'(8'h10 + i), bilerp_ref(tx, fu, fv), 1'b1);
            collect("random", 10);
        end

        // back-pressure with a competing request pending
        bus.rsp_ready = 1'b0;
        tx = {$urandom, $urandom, $urandom, $urandom};
        ex = bilerp_ref(tx, 8'h6C, 8'hA1);
        send(1'b1, tx, 8'h6C, 8'hA1, 8'h77, ex, 1'b1);
        begin
            int n = 1;
            while (!bus.rsp_valid && n < 64) begin
                @(negedge clk);
                n++;
            end
            chk("bp_latency", 32'(n), 32'd10);
        end
        drive(1'b0, {4{32'hDEADBEEF}}, 8'h00, 8'h00, 8'hEE);
        for (int i = 0; i < 20; i++) begin
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_color", bus.rsp_color, ex);
            chk("bp_rsp_tag", 32'(bus.rsp_tag), 32'h77);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        collect("bp_release", 1);
        chk("bp_req_ready_after", 32'(bus.req_ready), 32'd1);
        chk("bp_rsp_valid_after", 32'(bus.rsp_valid), 32'd0);

        // back-to-back with req_valid and rsp_ready held high
        for (int i = 0; i < 3; i++) begin
            bb_tx[i] = {$urandom, $urandom, $urandom, $urandom};
            bb_fu[i] = 8'($urandom);
            bb_fv[i] = 8'($urandom);
        end
        got  = 0;
        sent = 0;
        last = 0;
        pend = 1'b0;
        drive(1'b1, bb_tx[0], bb_fu[0], bb_fv[0], 8'hA0);
        for (int n = 0; n < 200 && got < 3; n++) begin
            if (pend) begin
                sb.push_back('{color: bilerp_ref(bb_tx[sent], bb_fu[sent], bb_fv[sent]),
                               tag: 8'(8'hA0 + sent)});
                sent++;
                if (sent < 3) drive(1'b1, bb_tx[sent], bb_fu[sent], bb_fv[sent], 8'(8'hA0 + sent));
                else bus.req_valid = 1'b0;
            end
            pend = bus.req_valid && bus.req_ready;
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL b2b_scoreboard observed=empty expected=entry");
                end else begin
                    e = sb.pop_front();
                    chk("b2b_color", bus.rsp_color, e.color);
                    chk("b2b_tag", 32'(bus.rsp_tag), 32'(e.tag));
                end
                if (got > 0) chk("b2b_spacing", 32'(n - last), 32'd11);
                last = n;
                got++;
            end
            @(negedge clk);
        end
        chk("b2b_count", 32'(got), 32'd3);
        bus.req_valid = 1'b0;

        // reset while waiting on the horizontal results
        tx = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        send(1'b1, tx, 8'h80, 8'h80, 8'h99, 32'hFFFFFFFF, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_rsp_color", bus.rsp_color, 32'd0);
        tx = {32'h20406080, 32'h10305070, 32'h08182838, 32'h04142434};
        send(1'b1, tx, 8'h33, 8'hC4, 8'h42, bilerp_ref(tx, 8'h33, 8'hC4), 1'b1);
        collect("after_abort", 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
